// File: rtl/data_mem_ctrl_if.sv
// CPU data-port and IO-peripheral signal bundle for data_mem_ctrl.
// master = CPU/peripheral side, slave = controller side.
interface data_mem_ctrl_if;
  logic        WriteMem;
  logic        ReadMem;
  logic [15:0] ExternalAddr;
  logic [15:0] ExternalWriteData;
  logic [15:0] ExternalReadData;
  logic        MemStall;
  logic        IoReq;
  logic        IoWr;
  logic [7:0]  IoAddr;
  logic [15:0] IoWrData;
  logic [15:0] IoRdData;
  logic        IoAck;
  logic        BusError;
  logic [15:0] ErrAddr;

  modport master (
    output WriteMem, ReadMem,
    output ExternalAddr, ExternalWriteData,
    output IoRdData, IoAck,
    input  ExternalReadData, MemStall,
    input  IoReq, IoWr, IoAddr, IoWrData,
    input  BusError, ErrAddr
  );

  modport slave (
    input  WriteMem, ReadMem,
    input  ExternalAddr, ExternalWriteData,
    input  IoRdData, IoAck,
    output ExternalReadData, MemStall,
    output IoReq, IoWr, IoAddr, IoWrData,
    output BusError, ErrAddr
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Data-port responder: single-cycle RAM, stalling IO window,
// and sticky error capture for unmapped or failed accesses.
module data_mem_ctrl #(
  parameter int          RAM_AW  = 10,
  parameter logic [15:0] IO_BASE = 16'hFF00,
  parameter int          TIMEOUT = 15
) (
  input logic           clk,
  input logic           rst,
  data_mem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;

  localparam logic [16:0] RAM_WORDS = 17'(2**RAM_AW);

  state_e      state_q, state_d;
  logic [15:0] rdata_q, rdata_d;
  logic [15:0] ioa_q, ioa_d;
  logic [15:0] iowd_q, iowd_d;
  logic        iowr_q, iowr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        berr_q, berr_d;
  logic [15:0] erra_q, erra_d;

  logic [15:0] mem [2**RAM_AW];

  logic              req, both;
  logic              ram_hit, io_hit;
  logic              ram_we, err_set, stall;
  logic [15:0]       err_addr;
  logic [RAM_AW-1:0] ram_a;

  assign req     = bus.WriteMem | bus.ReadMem;
  assign both    = bus.WriteMem & bus.ReadMem;
  assign ram_a   = bus.ExternalAddr[RAM_AW-1:0];
  assign ram_hit = {1'b0, bus.ExternalAddr} < RAM_WORDS;
  assign io_hit  = bus.ExternalAddr >= IO_BASE;

  always_comb begin
    state_d  = state_q;
    rdata_d  = rdata_q;
    ioa_d    = ioa_q;
    iowd_d   = iowd_q;
    iowr_d   = iowr_q;
    cnt_d    = cnt_q;
    ram_we   = 1'b0;
    err_set  = 1'b0;
    stall    = 1'b0;
    err_addr = bus.ExternalAddr;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (both) err_set = 1'b1;
          if (ram_hit) begin
            ram_we = bus.WriteMem;
            if (!bus.WriteMem) rdata_d = mem[ram_a];
          end else if (io_hit) begin
            stall   = 1'b1;
            ioa_d   = bus.ExternalAddr;
            iowd_d  = bus.ExternalWriteData;
            iowr_d  = bus.WriteMem;
            cnt_d   = 8'd0;
            state_d = REQ;
          end else begin
            err_set = 1'b1;
            if (!bus.WriteMem) rdata_d = 16'h0000;
          end
        end
      end
      REQ: begin
        stall = 1'b1;
        cnt_d = cnt_q + 8'd1;
        if (bus.IoAck) begin
          if (!iowr_q) rdata_d = bus.IoRdData;
          state_d = DONE;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          if (!iowr_q) rdata_d = 16'hDEAD;
          err_set  = 1'b1;
          err_addr = ioa_q;
          state_d  = DONE;
        end
      end
      // The request still visible here is the finished one.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    berr_d = berr_q | err_set;
    erra_d = (err_set && !berr_q) ? err_addr : erra_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rdata_q <= '0;
      ioa_q   <= '0;
      iowd_q  <= '0;
      iowr_q  <= 1'b0;
      cnt_q   <= '0;
      berr_q  <= 1'b0;
      erra_q  <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      ioa_q   <= ioa_d;
      iowd_q  <= iowd_d;
      iowr_q  <= iowr_d;
      cnt_q   <= cnt_d;
      berr_q  <= berr_d;
      erra_q  <= erra_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_a] <= bus.ExternalWriteData;
  end

  assign bus.ExternalReadData = rdata_q;
  assign bus.MemStall         = stall;
  assign bus.IoReq            = (state_q == REQ);
  assign bus.IoWr             = iowr_q;
  assign bus.IoAddr           = ioa_q[7:0];
  assign bus.IoWrData         = iowd_q;
  assign bus.BusError         = berr_q;
  assign bus.ErrAddr          = erra_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: RAM, IO handshake,
// timeout, unmapped decode, dual request and reset mid-IO.
module tb_data_mem_ctrl;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  data_mem_ctrl_if bus();

  data_mem_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic we, input logic re,
                       input logic [15:0] a,
                       input logic [15:0] d);
    bus.WriteMem          = we;
    bus.ReadMem           = re;
    bus.ExternalAddr      = a;
    bus.ExternalWriteData = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 16'h0, 16'h0);
    bus.IoAck = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(0, 0, 16'h0, 16'h0);
    bus.IoAck    = 1'b0;
    bus.IoRdData = 16'h0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (bus.IoReq !== 1'b0 || bus.MemStall !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_ctl: req=%b stall=%b want 0 0",
               bus.IoReq, bus.MemStall);
    end
    n_cmp++;
    if (bus.ExternalReadData !== 16'h0) begin
      n_bad++;
      $display("FAIL rst_rdata: got %h want 0000",
               bus.ExternalReadData);
    end
    n_cmp++;
    if (bus.BusError !== 1'b0 || bus.ErrAddr !== 16'h0) begin
      n_bad++;
      $display("FAIL rst_err: got %b/%h want 0/0000",
               bus.BusError, bus.ErrAddr);
    end
    rst = 1'b1;
  endtask

  task automatic test_ram_rw();
    @(negedge clk);
    drive(1, 0, 16'h0005, 16'h1234);
    #1;
    n_cmp++;
    if (bus.MemStall !== 1'b0) begin
      n_bad++;
      $display("FAIL ram_wr_stall: got %b want 0", bus.MemStall);
    end
    @(negedge clk);
    drive(0, 1, 16'h0005, 16'h0);
    #1;
    n_cmp++;
    if (bus.MemStall !== 1'b0 || bus.ExternalReadData !== 16'h0) begin
      n_bad++;
      $display("FAIL ram_rd_pre: stall=%b rd=%h want 0 0000",
               bus.MemStall, bus.ExternalReadData);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.ExternalReadData !== 16'h1234) begin
      n_bad++;
      $display("FAIL ram_raw: got %h want 1234",
               bus.ExternalReadData);
    end
    drive(0, 0, 16'h0, 16'h0);
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1, 0, 16'(16'h0010 + i), 16'(16'hA000 + i));
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i > 0) begin
        exp = 16'(16'hA000 + i - 1);
        n_cmp++;
        if (bus.ExternalReadData !== exp ||
            bus.MemStall !== 1'b0) begin
          n_bad++;
          $display("FAIL b2b_rd%0d: got %h stall=%b want %h 0",
                   i - 1, bus.ExternalReadData, bus.MemStall, exp);
        end
      end
      if (i < 4) drive(0, 1, 16'(16'h0010 + i), 16'h0);
      else       drive(0, 0, 16'h0, 16'h0);
    end
  endtask

  task automatic test_io_read();
    int stalls;
    stalls = 0;
    @(negedge clk);
    drive(0, 1, 16'hFF10, 16'h0);
    #1;
    if (bus.MemStall) stalls++;
    @(negedge clk);
    if (bus.MemStall) stalls++;
    n_cmp++;
    if (bus.IoReq !== 1'b1 || bus.IoAddr !== 8'h10 ||
        bus.IoWr !== 1'b0) begin
      n_bad++;
      $display("FAIL io_rd_req: req=%b addr=%h wr=%b want 1 10 0",
               bus.IoReq, bus.IoAddr, bus.IoWr);
    end
    @(negedge clk);
    if (bus.MemStall) stalls++;
    @(negedge clk);
    if (bus.MemStall) stalls++;
    bus.IoAck    = 1'b1;
    bus.IoRdData = 16'hBEEF;
    @(negedge clk);
    bus.IoAck = 1'b0;
    if (bus.MemStall) stalls++;
    n_cmp++;
    if (stalls !== 4) begin
      n_bad++;
      $display("FAIL io_rd_stalls: got %0d want 4", stalls);
    end
    n_cmp++;
    if (bus.IoReq !== 1'b0 ||
        bus.ExternalReadData !== 16'hBEEF) begin
      n_bad++;
      $display("FAIL io_rd_done: req=%b rd=%h want 0 beef",
               bus.IoReq, bus.ExternalReadData);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.IoReq !== 1'b0) begin
      n_bad++;
      $display("FAIL io_rd_relaunch: req=%b want 0", bus.IoReq);
    end
    drive(0, 0, 16'h0, 16'h0);
  endtask

  task automatic test_io_timeout();
    int  hi;
    bit  seen;
    bit  done;
    hi   = 0;
    seen = 1'b0;
    done = 1'b0;
    @(negedge clk);
    drive(1, 0, 16'hFF02, 16'h00AA);
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (bus.IoReq) begin
        if (!seen) begin
          n_cmp++;
          if (bus.IoWr !== 1'b1 || bus.IoWrData !== 16'h00AA ||
              bus.IoAddr !== 8'h02) begin
            n_bad++;
            $display("FAIL io_wr_lat: wr=%b d=%h a=%h want 1 00aa 02",
                     bus.IoWr, bus.IoWrData, bus.IoAddr);
          end
        end
        seen = 1'b1;
        hi++;
      end else if (seen) begin
        done = 1'b1;
      end
    end
    drive(0, 0, 16'h0, 16'h0);
    n_cmp++;
    if (!done || hi !== 15) begin
      n_bad++;
      $display("FAIL io_to_len: done=%b cycles=%0d want 1 15",
               done, hi);
    end
    n_cmp++;
    if (bus.BusError !== 1'b1 || bus.ErrAddr !== 16'hFF02 ||
        bus.ExternalReadData !== 16'hBEEF) begin
      n_bad++;
      $display("FAIL io_to_err: be=%b ea=%h rd=%h want 1 ff02 beef",
               bus.BusError, bus.ErrAddr, bus.ExternalReadData);
    end
    @(negedge clk);
    drive(0, 1, 16'hFF03, 16'h0);
    repeat (16) @(negedge clk);
    n_cmp++;
    if (bus.IoReq !== 1'b0 || bus.MemStall !== 1'b0 ||
        bus.ExternalReadData !== 16'hDEAD ||
        bus.ErrAddr !== 16'hFF02) begin
      n_bad++;
      $display("FAIL io_to_rd: req=%b st=%b rd=%h ea=%h want 0 0 dead ff02",
               bus.IoReq, bus.MemStall, bus.ExternalReadData,
               bus.ErrAddr);
    end
    drive(0, 0, 16'h0, 16'h0);
  endtask

  task automatic test_unmapped();
    do_reset();
    @(negedge clk);
    drive(0, 1, 16'h0005, 16'h0);
    @(negedge clk);
    n_cmp++;
    if (bus.ExternalReadData !== 16'h1234) begin
      n_bad++;
      $display("FAIL um_ram_keep: got %h want 1234",
               bus.ExternalReadData);
    end
    drive(0, 1, 16'h8000, 16'h0);
    #1;
    n_cmp++;
    if (bus.MemStall !== 1'b0) begin
      n_bad++;
      $display("FAIL um_stall: got %b want 0", bus.MemStall);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.ExternalReadData !== 16'h0 || bus.BusError !== 1'b1 ||
        bus.ErrAddr !== 16'h8000) begin
      n_bad++;
      $display("FAIL um_first: rd=%h be=%b ea=%h want 0000 1 8000",
               bus.ExternalReadData, bus.BusError, bus.ErrAddr);
    end
    drive(0, 1, 16'h9000, 16'h0);
    @(negedge clk);
    n_cmp++;
    if (bus.ErrAddr !== 16'h8000 || bus.BusError !== 1'b1) begin
      n_bad++;
      $display("FAIL um_sticky: ea=%h be=%b want 8000 1",
               bus.ErrAddr, bus.BusError);
    end
    drive(1, 0, 16'h03FF, 16'h7777);
    @(negedge clk);
    drive(0, 1, 16'h03FF, 16'h0);
    @(negedge clk);
    n_cmp++;
    if (bus.ExternalReadData !== 16'h7777) begin
      n_bad++;
      $display("FAIL ram_top: got %h want 7777",
               bus.ExternalReadData);
    end
    drive(0, 1, 16'h0400, 16'h0);
    @(negedge clk);
    n_cmp++;
    if (bus.ExternalReadData !== 16'h0) begin
      n_bad++;
      $display("FAIL ram_end: got %h want 0000",
               bus.ExternalReadData);
    end
    drive(0, 1, 16'hFEFF, 16'h0);
    #1;
    n_cmp++;
    if (bus.MemStall !== 1'b0) begin
      n_bad++;
      $display("FAIL io_below: stall=%b want 0", bus.MemStall);
    end
    @(negedge clk);
    drive(0, 0, 16'h0, 16'h0);
  endtask

  task automatic test_both();
    do_reset();
    @(negedge clk);
    drive(0, 1, 16'h0005, 16'h0);
    @(negedge clk);
    drive(1, 1, 16'h0003, 16'h5555);
    @(negedge clk);
    n_cmp++;
    if (bus.ExternalReadData !== 16'h1234 ||
        bus.BusError !== 1'b1 || bus.ErrAddr !== 16'h0003) begin
      n_bad++;
      $display("FAIL both: rd=%h be=%b ea=%h want 1234 1 0003",
               bus.ExternalReadData, bus.BusError, bus.ErrAddr);
    end
    drive(0, 1, 16'h0003, 16'h0);
    @(negedge clk);
    n_cmp++;
    if (bus.ExternalReadData !== 16'h5555) begin
      n_bad++;
      $display("FAIL both_wr: got %h want 5555",
               bus.ExternalReadData);
    end
    drive(0, 0, 16'h0, 16'h0);
  endtask

  task automatic test_reset_mid_io();
    do_reset();
    @(negedge clk);
    drive(0, 1, 16'hFF20, 16'h0);
    @(negedge clk);
    n_cmp++;
    if (bus.IoReq !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_req: got %b want 1", bus.IoReq);
    end
    #2;
    rst = 1'b0;
    drive(0, 0, 16'h0, 16'h0);
    #1;
    n_cmp++;
    if (bus.IoReq !== 1'b0 || bus.MemStall !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_drop: req=%b st=%b want 0 0",
               bus.IoReq, bus.MemStall);
    end
    @(negedge clk);
    rst          = 1'b1;
    bus.IoRdData = 16'h1111;
    bus.IoAck    = 1'b1;
    @(negedge clk);
    bus.IoAck = 1'b0;
    n_cmp++;
    if (bus.IoReq !== 1'b0 || bus.MemStall !== 1'b0 ||
        bus.ExternalReadData !== 16'h0 ||
        bus.BusError !== 1'b0) begin
      n_bad++;
      $display("FAIL late_ack: req=%b st=%b rd=%h be=%b want 0 0 0000 0",
               bus.IoReq, bus.MemStall, bus.ExternalReadData,
               bus.BusError);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_ram_rw();
    test_back_to_back();
    test_io_read();
    test_io_timeout();
    test_unmapped();
    test_both();
    test_reset_mid_io();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Memory-side responder for the CPU's external data port. It services the WriteMem/ReadMem/ExternalAddr/ExternalWriteData requests issued from the memory stage and returns ExternalReadData. Requests decode to one of three regions: internal data RAM (single-cycle), a memory-mapped IO window (req/ack handshake with CPU stall), or unmapped space (error capture). It sits between proc and the game peripherals.

Parameters:
RAM_AW, 10, RAM word-address width; RAM holds 2^RAM_AW 16-bit words at addresses 0 to 2^RAM_AW-1.
IO_BASE, 16'hFF00, first IO address; the IO window runs from IO_BASE to 16'hFFFF, and IoAddr is the low 8 bits.
TIMEOUT, 15, maximum REQ-state cycles without IoAck before the access aborts (must be 1 to 255).

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low
WriteMem  in  1  CPU store request
ReadMem  in  1  CPU load request
ExternalAddr  in  16  CPU word address
ExternalWriteData  in  16  CPU store data
ExternalReadData  out  16  load data to CPU (registered)
MemStall  out  1  freezes the CPU pipeline while an IO access is outstanding
IoReq  out  1  IO request strobe, level-held until ack or timeout
IoWr  out  1  1 = IO write, 0 = IO read; valid while IoReq
IoAddr  out  8  IO register index
IoWrData  out  16  IO write data
IoRdData  in  16  IO read data; sampled when IoAck
IoAck  in  1  one-cycle peripheral completion
BusError  out  1  sticky error flag
ErrAddr  out  16  address of the first erroring access

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; ExternalReadData=0, MemStall=0, IoReq=0, IoWr=0, IoAddr=0, IoWrData=0, BusError=0, ErrAddr=0, timeout counter=0. RAM contents are not reset.
- A reset asserted mid-IO access drops IoReq immediately. A late IoAck after reset is ignored.
- Request = WriteMem|ReadMem. If both are asserted, the access is a write, BusError is set, and ExternalReadData holds its value.
- Decode: addr < 2^RAM_AW selects RAM. addr >= IO_BASE selects IO. Anything else is unmapped.
- RAM write: memory is updated at the clock edge of the request cycle.
- RAM read: ExternalReadData is loaded at that edge and is valid the next cycle (1-cycle latency).
- Read-after-write: a read of an address written in the previous cycle returns the new data.
- RAM accesses never assert MemStall, and back-to-back accesses run every cycle.
- ExternalReadData changes only when a read completes; it holds otherwise.
- IO FSM states: IDLE, REQ, DONE.
  - IDLE, IO hit: MemStall=1 combinationally in the same cycle. Latch IoAddr, IoWrData and IoWr. Next state is REQ with IoReq=1 and counter=0.
  - REQ: MemStall=1, IoReq=1, counter increments each cycle.
  - REQ with IoAck: on a read, ExternalReadData<=IoRdData. IoReq drops at the edge. Next state is DONE.
  - REQ with counter==TIMEOUT-1 and no ack: abort. A read returns 16'hDEAD. BusError is set. Next state is DONE.
  - An ack and a timeout in the same cycle count as an ack.
  - DONE: MemStall=0 and IoReq=0, so the CPU advances at this edge. The still-visible request belongs to the completed instruction and is not relaunched. DONE always goes to IDLE.
  - A new IO access is accepted no earlier than the cycle after DONE. IO read data is valid from the DONE cycle onward.
- IoAck outside REQ is ignored.
- Unmapped access: no stall. Writes are dropped. A read loads ExternalReadData=0. BusError is set.
- Error capture: BusError is sticky until reset. ErrAddr is captured only on the 0->1 transition of BusError, i.e. first error wins.
- IO aborts record the latched IO address; other errors record ExternalAddr.

Test Plan:
- RAM write 0x1234 to 0x0005, then read 0x0005 in the next cycle -> ExternalReadData=0x1234 one cycle after the read; MemStall stays 0 throughout.
- IO read at 0xFF10; peripheral acks after 3 REQ cycles with IoRdData=0xBEEF -> MemStall high for 4 cycles (IDLE cycle plus 3 REQ), IoAddr=0x10, IoWr=0; ExternalReadData=0xBEEF in the DONE cycle; no second IoReq while the request is held during DONE.
- IO write at 0xFF02 with data 0x00AA and no ack, TIMEOUT=15 -> IoReq high for exactly 15 cycles, then DONE; BusError=1, ErrAddr=0xFF02.
- Read at unmapped 0x8000, then a later read at unmapped 0x9000 -> ExternalReadData=0 with no stall; BusError=1; ErrAddr stays 0x8000.
- WriteMem and ReadMem both asserted at 0x0003 with data 0x5555 -> RAM[3]=0x5555; ExternalReadData unchanged; BusError=1.
- Assert rst=0 during an IO REQ at 0xFF20 -> IoReq and MemStall drop immediately; after release, state=IDLE; an IoAck arriving now is ignored.
